// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access-size and FSM state encodings,
// plus the alignment rule used to reject a request before it reaches memory.
package mem_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } mau_state_e;

   // An illegal size counts as misaligned so it takes the error path.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = off[0];
         SIZE_WORD: bad = (off != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte enables and lane-shifted write data for a
// right-justified store value at a given byte offset within the word.
module store_align
   import mem_pkg::*;
#(
   parameter int width = 32
) (
   input  mem_size_e          size_i,
   input  logic [1:0]         offset_i,
   input  logic [width-1:0]   wdata_i,
   output logic [3:0]         byte_enable_o,
   output logic [width-1:0]   wdata_o
);

   // Byte enables; the illegal size never reaches WRITE, so it enables nothing.
   always_comb begin
      byte_enable_o = 4'b0000;
      case (size_i)
         SIZE_BYTE: byte_enable_o = 4'b0001 << offset_i;
         SIZE_HALF: byte_enable_o = 4'b0011 << offset_i;
         SIZE_WORD: byte_enable_o = 4'b1111;
         default:   byte_enable_o = 4'b0000;
      endcase
   end

   assign wdata_o = wdata_i << {offset_i, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one request, runs a single memory access with a
// held strobe until mem_resp, then pulses rsp_valid with latched response fields.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int width = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [1:0]         req_size,
   input  logic [width-1:0]   req_addr,
   input  logic [width-1:0]   req_wdata,
   output logic [width-1:0]   mem_address,
   output logic               mem_read,
   output logic               mem_write,
   output logic [3:0]         mem_byte_enable,
   output logic [width-1:0]   mem_wdata,
   input  logic [width-1:0]   mem_rdata,
   input  logic               mem_resp,
   output logic               rsp_valid,
   output logic [width-1:0]   rsp_rdata,
   output logic [1:0]         rsp_offset,
   output logic               rsp_error
);

   mau_state_e          state_q, state_d;
   logic [width-1:0]    addr_q, addr_d;
   mem_size_e           size_q, size_d;
   logic                write_q, write_d;
   logic [width-1:0]    wdata_q, wdata_d;
   logic [width-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_offset_q, rsp_offset_d;
   logic                rsp_error_q, rsp_error_d;

   logic                req_ready_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic [3:0]          mem_be_q;
   logic [width-1:0]    mem_wdata_q;
   logic                rsp_valid_q;

   logic [3:0]          be_s;
   logic [width-1:0]    wdata_shift_s;

   // Alignment is computed from the next-cycle latch so the strobe-side outputs
   // can be registered and still be valid on the first WRITE cycle.
   store_align #(.width(width)) u_store_align (
      .size_i        (size_d),
      .offset_i      (addr_d[1:0]),
      .wdata_i       (wdata_d),
      .byte_enable_o (be_s),
      .wdata_o       (wdata_shift_s)
   );

   // Next-state, request latch and response latch update.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_offset_d = rsp_offset_q;
      rsp_error_d  = rsp_error_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = mem_size_e'(req_size);
               write_d = req_write;
               wdata_d = req_wdata;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  state_d      = ST_DONE;
                  rsp_rdata_d  = {width{1'b0}};
                  rsp_offset_d = req_addr[1:0];
                  rsp_error_d  = 1'b1;
               end else if (req_write) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (mem_resp) begin
               state_d      = ST_DONE;
               rsp_rdata_d  = mem_rdata;
               rsp_offset_d = addr_q[1:0];
               rsp_error_d  = 1'b0;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (mem_resp) begin
               state_d      = ST_DONE;
               rsp_rdata_d  = {width{1'b0}};
               rsp_offset_d = addr_q[1:0];
               rsp_error_d  = 1'b0;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latches and registered outputs; reset drops the strobes at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= {width{1'b0}};
         size_q       <= SIZE_BYTE;
         write_q      <= 1'b0;
         wdata_q      <= {width{1'b0}};
         rsp_rdata_q  <= {width{1'b0}};
         rsp_offset_q <= 2'b00;
         rsp_error_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= {width{1'b0}};
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_offset_q <= rsp_offset_d;
         rsp_error_q  <= rsp_error_d;
         req_ready_q  <= (state_d == ST_IDLE);
         mem_read_q   <= (state_d == ST_READ);
         mem_write_q  <= (state_d == ST_WRITE);
         mem_be_q     <= (state_d == ST_WRITE) ? be_s : 4'b0000;
         mem_wdata_q  <= wdata_shift_s;
         rsp_valid_q  <= (state_d == ST_DONE);
      end
   end

   assign req_ready       = req_ready_q;
   assign mem_address     = {addr_q[width-1:2], 2'b00};
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_byte_enable = mem_be_q;
   assign mem_wdata       = mem_wdata_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_offset      = rsp_offset_q;
   assign rsp_error       = rsp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of load/store vectors with
// hand-computed results, plus reset, spurious-response and mid-access reset sequences.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_offset;
   logic        rsp_error;

   int errors = 0;
   int checks = 0;

   mem_access_unit #(.width(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_size        (req_size),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_offset      (rsp_offset),
      .rsp_error       (rsp_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_err;
      logic [31:0] e_rdata;
      logic [1:0]  e_off;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int waited;
      waited = 0;
      while (!req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk($sformatf("v%0d ready_before_req", idx), {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_write = v.wr;
      req_size  = v.size;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5555_5555;
      if (!v.e_err) begin
         for (int k = 1; k <= v.delay; k++) begin
            chk($sformatf("v%0d mem_read c%0d", idx, k),  {31'd0, mem_read},  {31'd0, !v.wr});
            chk($sformatf("v%0d mem_write c%0d", idx, k), {31'd0, mem_write}, {31'd0, v.wr});
            chk($sformatf("v%0d mem_address c%0d", idx, k), mem_address, v.e_addr);
            chk($sformatf("v%0d byte_enable c%0d", idx, k), {28'd0, mem_byte_enable}, {28'd0, v.e_be});
            if (v.wr) chk($sformatf("v%0d mem_wdata c%0d", idx, k), mem_wdata, v.e_wdata);
            chk($sformatf("v%0d rsp_valid_early c%0d", idx, k), {31'd0, rsp_valid}, 32'd0);
            if (k == v.delay) begin
               mem_resp  = 1'b1;
               mem_rdata = v.rdata;
            end
            @(negedge clk);
            mem_resp  = 1'b0;
            mem_rdata = 32'hA5A5_A5A5;
         end
      end
      chk($sformatf("v%0d rsp_valid", idx),  {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d ready_in_done", idx), {31'd0, req_ready}, 32'd0);
      chk($sformatf("v%0d no_strobe_done", idx), {30'd0, mem_read, mem_write}, 32'd0);
      chk($sformatf("v%0d be_done", idx), {28'd0, mem_byte_enable}, 32'd0);
      chk($sformatf("v%0d rsp_error", idx),  {31'd0, rsp_error}, {31'd0, v.e_err});
      chk($sformatf("v%0d rsp_rdata", idx),  rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d rsp_offset", idx), {30'd0, rsp_offset}, {30'd0, v.e_off});
      @(negedge clk);
      chk($sformatf("v%0d rsp_valid_drop", idx), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("v%0d ready_after", idx),    {31'd0, req_ready}, 32'd1);
      chk($sformatf("v%0d rsp_rdata_hold", idx), rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d rsp_error_hold", idx), {31'd0, rsp_error}, {31'd0, v.e_err});
   endtask

   initial begin
      vec_t spur;
      //          wr    size   addr          wdata         rdata        dly  e_addr        e_be     e_wdata       err   e_rdata       off
      vecs[0] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 32'h0000_0100, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF, 2'd0};
      vecs[1] = '{1'b0, 2'b10, 32'h0000_0101, 32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        2'd1};
      vecs[2] = '{1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'h0,       1, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 1'b0, 32'h0,        2'd3};
      vecs[3] = '{1'b1, 2'b01, 32'h0000_0102, 32'h0000_1234, 32'h0,       2, 32'h0000_0100, 4'b1100, 32'h1234_0000, 1'b0, 32'h0,        2'd2};
      vecs[4] = '{1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,       2, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        2'd0};
      vecs[5] = '{1'b0, 2'b00, 32'h0000_0401, 32'h0,        32'h1122_3344, 1, 32'h0000_0400, 4'b0000, 32'h0,       1'b0, 32'h1122_3344, 2'd1};
      vecs[6] = '{1'b1, 2'b11, 32'h0000_0500, 32'h0000_0077, 32'h0,       1, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        2'd0};
      vecs[7] = '{1'b1, 2'b01, 32'h0000_0203, 32'h0000_BEEF, 32'h0,       1, 32'h0,         4'b0000, 32'h0,        1'b1, 32'h0,        2'd3};
      vecs[8] = '{1'b1, 2'b00, 32'h0000_0001, 32'h0000_005A, 32'h0,       1, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 1'b0, 32'h0,        2'd1};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size  = 2'b00;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_rdata = 32'h0;
      mem_resp  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset req_ready",   {31'd0, req_ready}, 32'd1);
      chk("reset strobes",     {30'd0, mem_read, mem_write}, 32'd0);
      chk("reset rsp_valid",   {31'd0, rsp_valid}, 32'd0);
      chk("reset mem_address", mem_address, 32'h0);
      chk("reset byte_enable", {28'd0, mem_byte_enable}, 32'd0);
      chk("reset mem_wdata",   mem_wdata, 32'h0);
      chk("reset rsp_rdata",   rsp_rdata, 32'h0);
      chk("reset rsp_offset_error", {29'd0, rsp_offset, rsp_error}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Spurious mem_resp while idle must not start or complete anything.
      mem_resp  = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      mem_resp = 1'b0;
      chk("spurious ready",     {31'd0, req_ready}, 32'd1);
      chk("spurious rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("spurious rsp_rdata", rsp_rdata, 32'h0000_0000);
      spur = '{1'b0, 2'b01, 32'h0000_0606, 32'h0, 32'h7788_99AA, 3, 32'h0000_0604, 4'b0000, 32'h0, 1'b0, 32'h7788_99AA, 2'd2};
      run_vec(spur, 9);

      // Reset in the middle of a load: strobe drops asynchronously, no response later.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h0000_0800;
      @(negedge clk);
      req_valid = 1'b0;
      chk("midrst mem_read before", {31'd0, mem_read}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst mem_read async", {31'd0, mem_read}, 32'd0);
      chk("midrst req_ready",      {31'd0, req_ready}, 32'd1);
      chk("midrst rsp_rdata",      rsp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) mem_resp = 1'b1;
         @(negedge clk);
         mem_resp = 1'b0;
         chk($sformatf("midrst no_rsp c%0d", c),   {31'd0, rsp_valid}, 32'd0);
         chk($sformatf("midrst ready c%0d", c),    {31'd0, req_ready}, 32'd1);
         chk($sformatf("midrst no_strobe c%0d", c), {30'd0, mem_read, mem_write}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter width, default 32, the data and address width in bits.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port req_valid  input  1  datapath presents a load or store request.
REQ-005 Port req_ready  output  1  block can accept a request this cycle.
REQ-006 Port req_write  input  1  1 = store, 0 = load.
REQ-007 Port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 Port req_addr  input  width  byte address of the access.
REQ-009 Port req_wdata  input  width  store data, right-justified.
REQ-010 Port mem_address  output  width  word-aligned memory address.
REQ-011 Port mem_read  output  1  memory read strobe.
REQ-012 Port mem_write  output  1  memory write strobe.
REQ-013 Port mem_byte_enable  output  4  store byte lanes.
REQ-014 Port mem_wdata  output  width  lane-shifted store data.
REQ-015 Port mem_rdata  input  width  memory read word.
REQ-016 Port mem_resp  input  1  memory completion, one cycle.
REQ-017 Port rsp_valid  output  1  one-cycle completion pulse to the downstream load-extract stage.
REQ-018 Port rsp_rdata  output  width  latched raw memory word, unshifted.
REQ-019 Port rsp_offset  output  2  latched req_addr[1:0], used by the extract stage for lane select.
REQ-020 Port rsp_error  output  1  the request was misaligned or illegal, and no memory access occurred.

Function
REQ-021 The FSM SHALL have states IDLE, READ, WRITE and DONE; req_ready SHALL equal 1 only in IDLE.
REQ-022 On IDLE with req_valid=1, the block SHALL latch addr, size, write and wdata, and the next state SHALL be READ or WRITE, or DONE with error set if the request is misaligned.
REQ-023 A request SHALL be misaligned when it is half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-024 In READ, mem_read SHALL be 1; in WRITE, mem_write SHALL be 1; each SHALL be held until mem_resp=1 is sampled, with the next state DONE.
REQ-025 mem_address SHALL be {addr[width-1:2],2'b00}, driven from the latch and stable for the whole access.
REQ-026 mem_byte_enable SHALL be 0001<<off for byte, 0011<<off for half and 1111 for word, and SHALL be 0000 outside WRITE.
REQ-027 mem_wdata SHALL be wdata<<(8*off).
REQ-028 On a load, mem_rdata SHALL be captured into rsp_rdata in the cycle mem_resp=1; on a store or on error, rsp_rdata SHALL hold 0.
REQ-029 In DONE, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-030 rsp_rdata, rsp_offset and rsp_error SHALL hold their values until the next request completes.
REQ-031 Latency SHALL be: accept at cycle N, strobe from N+1, mem_resp at cycle M, rsp_valid at M+1; an error request SHALL have rsp_valid at N+1.
REQ-032 mem_resp SHALL be ignored in IDLE and DONE.
REQ-033 The block SHALL accept a new request no sooner than the IDLE cycle following DONE, so back-to-back throughput is one request per 3 cycles minimum.

Reset
REQ-034 When rst_n=0, the state SHALL be IDLE and all outputs and latches SHALL be 0, except req_ready, which SHALL be 1.
REQ-035 Reset asserted mid-access SHALL drop mem_read and mem_write immediately (asynchronously), and the in-flight request SHALL be discarded with no rsp_valid.

Structure
REQ-036 The access-size enum (byte/half/word) and the FSM state enum SHALL live in shared package mem_pkg.
REQ-037 Byte-enable and store-shift generation SHALL be one combinational sub-module, store_align.

Verification
REQ-038 Load word: addr=0x100, mem_resp at the 3rd strobe cycle with rdata=0xDEADBEEF -> mem_address=0x100, rsp_valid one cycle later, rsp_rdata=0xDEADBEEF, rsp_offset=0.
REQ-039 Store byte: addr=0x203, wdata=0x000000AB -> mem_address=0x200, byte_enable=1000, mem_wdata=0xAB000000, rsp_error=0.
REQ-040 Store half: addr=0x102, wdata=0x1234 -> byte_enable=1100, mem_wdata=0x12340000.
REQ-041 Misaligned: load word at addr=0x101 -> no mem_read at all, rsp_valid at N+1, rsp_error=1.
REQ-042 Reset mid-access: rst_n low while mem_read=1 -> mem_read=0 within the same cycle, req_ready=1, no rsp_valid after release.
REQ-043 Spurious mem_resp in IDLE, followed by a load -> the load completes normally, with a strobe held until its own mem_resp.
